// File: rtl/light_serialiser.sv
// light_serialiser: shifts a captured 24-bit {R,G,B} word out MSB first onto a
// single LED data line. Each bit occupies BIT_CYCLES clocks, and its high time
// (T1H or T0H) carries the bit value. A low latch gap follows every frame.
//
// Handshake: a word on `light` is taken at a rising edge where valid && ready.
// ready is high only while the block is idle. valid is ignored while a frame
// (SEND or LATCH) is in progress, and nothing is queued.
//
// Every output is a flop. The next-cycle value of dout is worked out from the
// next-state values, so dout rises in the cycle straight after the capture edge.
module light_serialiser #(
  parameter int BIT_CYCLES   = 10,
  parameter int T0H          = 3,
  parameter int T1H          = 7,
  parameter int LATCH_CYCLES = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] light,
  input  logic        valid,
  output logic        ready,
  output logic        dout,
  output logic        busy,
  output logic        done,
  output logic [1:0]  o_dbg_state
);

  localparam int CNT_MAX = (BIT_CYCLES > LATCH_CYCLES) ? BIT_CYCLES : LATCH_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] C_BIT_LAST   = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] C_LATCH_LAST = CW'(LATCH_CYCLES - 1);
  localparam logic [CW-1:0] C_T0H        = CW'(T0H);
  localparam logic [CW-1:0] C_T1H        = CW'(T1H);
  localparam logic [CW-1:0] C_ONE        = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cyc;
  logic [CW-1:0] w_cyc_nxt;
  logic [4:0]    r_bit;
  logic [4:0]    w_bit_nxt;
  logic [23:0]   r_shift;
  logic [23:0]   w_shift_nxt;
  logic [CW-1:0] w_high_len;
  logic          w_done_nxt;
  logic          w_dout_nxt;

  logic r_ready;
  logic r_dout;
  logic r_busy;
  logic r_done;

  // Next-state, counter and shift-register logic; also the next dout level.
  always_comb begin
    w_state_nxt = r_state;
    w_cyc_nxt   = r_cyc;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_done_nxt  = 1'b0;

    case (r_state)
      IDLE: begin
        if (valid && r_ready) begin
          w_state_nxt = SEND;
          w_shift_nxt = light;
          w_bit_nxt   = 5'd23;
          w_cyc_nxt   = '0;
        end
      end
      SEND: begin
        if (r_cyc == C_BIT_LAST) begin
          w_cyc_nxt   = '0;
          w_shift_nxt = {r_shift[22:0], 1'b0};
          if (r_bit == 5'd0) begin
            w_state_nxt = LATCH;
          end else begin
            w_bit_nxt = r_bit - 5'd1;
          end
        end else begin
          w_cyc_nxt = r_cyc + C_ONE;
        end
      end
      LATCH: begin
        if (r_cyc == C_LATCH_LAST) begin
          w_state_nxt = IDLE;
          w_cyc_nxt   = '0;
          w_done_nxt  = 1'b1;
        end else begin
          w_cyc_nxt = r_cyc + C_ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cyc_nxt   = '0;
        w_bit_nxt   = '0;
      end
    endcase

    // The MSB of the shift register is always the bit currently being sent.
    w_high_len = w_shift_nxt[23] ? C_T1H : C_T0H;
    w_dout_nxt = (w_state_nxt == SEND) && (w_cyc_nxt < w_high_len);
  end

  // State, counters and the shift register; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cyc   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cyc   <= w_cyc_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // Registered outputs, derived from the state being entered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ready <= 1'b1;
      r_dout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_ready <= (w_state_nxt == IDLE);
      r_busy  <= (w_state_nxt != IDLE);
      r_dout  <= w_dout_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign ready       = r_ready;
  assign dout        = r_dout;
  assign busy        = r_busy;
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_light_serialiser.sv
// Bench for light_serialiser.
// The handshake model tracks when a frame is in flight from capture timing
// alone. Captured words are queued with the cycle in which they were captured.
// A dout decoder measures pulses and checks them against the queued word.
module tb_light_serialiser;

  localparam int BIT_CYCLES   = 10;
  localparam int T0H          = 3;
  localparam int T1H          = 7;
  localparam int LATCH_CYCLES = 50;
  localparam int FRAME        = 24 * BIT_CYCLES + LATCH_CYCLES;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid = 1'b0;
  logic [23:0] light = '0;
  logic        ready;
  logic        dout;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  light_serialiser #(
    .BIT_CYCLES  (BIT_CYCLES),
    .T0H         (T0H),
    .T1H         (T1H),
    .LATCH_CYCLES(LATCH_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .light      (light),
    .valid      (valid),
    .ready      (ready),
    .dout       (dout),
    .busy       (busy),
    .done       (done),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- reference model ----------------
  logic [23:0] exp_q[$];
  int          cap_q[$];
  logic        model_ready   = 1'b1;
  int          free_at       = 0;
  int          n_caps        = 0;
  bit          armed         = 1'b0;
  bit          last_edge_rst = 1'b0;

  // A frame is busy for FRAME edges after its capture; a word is captured when
  // the model is idle and valid is high.
  always @(posedge clk) begin
    last_edge_rst = !rst;
    if (!rst) begin
      armed       = 1'b1;
      model_ready = 1'b1;
      exp_q.delete();
      cap_q.delete();
    end else if (!model_ready) begin
      if (cyc == free_at) model_ready = 1'b1;
    end else if (valid) begin
      exp_q.push_back(light);
      cap_q.push_back(cyc);
      free_at     = cyc + FRAME;
      model_ready = 1'b0;
      n_caps++;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit          prev_dout     = 1'b0;
  bit          done_prev     = 1'b0;
  int          bit_idx       = 0;
  int          hi            = 0;
  int          last_rise     = 0;
  logic [23:0] word          = '0;
  logic [23:0] head;
  logic        exp_bit;
  bit          b2b_mode      = 1'b0;
  int          last_done_cyc = -1;

  always @(negedge clk) begin
    if (armed) begin
      if (last_edge_rst) begin
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_dout",  {31'd0, dout},  32'd0);
        check("rst_busy",  {31'd0, busy},  32'd0);
        check("rst_done",  {31'd0, done},  32'd0);
        prev_dout = 1'b0;
        done_prev = 1'b0;
        bit_idx   = 0;
        hi        = 0;
        word      = '0;
      end else begin
        check("ready", {31'd0, ready}, {31'd0, model_ready});
        check("busy",  {31'd0, busy},  {31'd0, !model_ready});
        if (done_prev) check("done_width", {31'd0, done}, 32'd0);
        done_prev = done;

        if (dout && !prev_dout) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_frame");
          end else if (bit_idx >= 24) begin
            fail_now("extra_bit");
          end else if (bit_idx == 0) begin
            check("first_rise", cyc, cap_q[0] + 1);
            if (b2b_mode && last_done_cyc >= 0)
              check("b2b_gap", cyc - last_done_cyc, 1);
          end else begin
            check("bit_period", cyc - last_rise, BIT_CYCLES);
          end
          last_rise = cyc;
          hi        = 1;
        end else if (dout) begin
          hi++;
        end else if (prev_dout) begin
          if (exp_q.size() != 0 && bit_idx < 24) begin
            head    = exp_q[0];
            exp_bit = head[23 - bit_idx];
            check("bit_high", hi, exp_bit ? T1H : T0H);
            word    = {word[22:0], (hi * 2 > T0H + T1H)};
            bit_idx++;
          end
        end

        if (done) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_done");
          end else begin
            check("bit_count",  bit_idx, 24);
            check("word",       {8'd0, word}, {8'd0, exp_q[0]});
            check("done_cycle", cyc, cap_q[0] + 1 + FRAME);
            check("latch_gap",  cyc - last_rise, BIT_CYCLES + LATCH_CYCLES);
            void'(exp_q.pop_front());
            void'(cap_q.pop_front());
            last_done_cyc = cyc;
            bit_idx       = 0;
            word          = '0;
          end
        end
        prev_dout = dout;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present w with valid until the model records a capture; optionally keep valid high.
  task automatic send(input logic [23:0] w, input bit hold);
    int c0;
    int k;
    c0    = n_caps;
    k     = 0;
    light = w;
    valid = 1'b1;
    while (n_caps == c0 && k < 2000) begin
      tick();
      k++;
    end
    if (n_caps == c0) fail_now("capture_timeout");
    if (!hold) begin
      valid = 1'b0;
      light = 24'($urandom);
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!(model_ready && exp_q.size() == 0) && k < 1000) begin
      tick();
      k++;
    end
    if (!(model_ready && exp_q.size() == 0)) fail_now("idle_timeout");
  endtask

  logic [23:0] colours [6] = '{24'hFF0000, 24'h00FF00, 24'h0000FF,
                               24'hFFFF00, 24'h00FFFF, 24'hFF00FF};

  // ---------------- stimulus ----------------
  initial begin
    // Reset held with valid high: no capture may happen.
    rst   = 1'b0;
    valid = 1'b1;
    light = 24'hABCDEF;
    repeat (3) tick();
    rst   = 1'b1;
    valid = 1'b0;
    tick();

    // All ones, all zeros, mixed pattern.
    send(24'hFFFFFF, 1'b0); wait_idle();
    send(24'h000000, 1'b0); wait_idle();
    send(24'hA50F3C, 1'b0); wait_idle();

    // valid during SEND is ignored; second word is captured when ready returns.
    send(24'h123456, 1'b0);
    send(24'hFFFFFF, 1'b0);
    wait_idle();

    // Abort in the middle of bit 12, then send a full frame.
    send(24'hC3C3C3, 1'b0);
    repeat (12 * BIT_CYCLES + 4) tick();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    send(24'h5A5A5A, 1'b0);
    wait_idle();

    // valid tied high, colours back to back.
    last_done_cyc = -1;
    b2b_mode      = 1'b1;
    for (int i = 0; i < 6; i++) send(colours[i], 1'b1);
    valid = 1'b0;
    wait_idle();
    b2b_mode = 1'b0;

    // Random words with random idle gaps and random valid/light noise.
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 4)) tick();
      send(24'($urandom), 1'b0);
      for (int j = 0; j < 100; j++) begin
        light = 24'($urandom);
        valid = ($urandom_range(0, 3) == 0);
        tick();
      end
      valid = 1'b0;
      wait_idle();
    end

    repeat (5) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Overall time bound.
  initial begin
    #2000000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $fatal(1, "time limit");
  end

endmodule
